// File: rtl/j1_io_pkg.sv
// j1_io_pkg: register map, STATUS/CTRL bit positions and UART FSM states
// shared by the J1 UART IO responder and its RX FIFO.
package j1_io_pkg;

    localparam logic [15:0] DATA_OFS   = 16'd0;
    localparam logic [15:0] STATUS_OFS = 16'd2;
    localparam logic [15:0] CTRL_OFS   = 16'd4;

    localparam int ST_RX_AVAIL   = 0;
    localparam int ST_TX_BUSY    = 1;
    localparam int ST_RX_OVERRUN = 2;
    localparam int ST_RX_FULL    = 3;

    localparam int CTRL_IRQ_EN   = 0;
    localparam int CTRL_LOOPBACK = 1;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

endpackage

// File: rtl/j1_uart_rx_fifo.sv
// j1_uart_rx_fifo: synchronous byte FIFO for received UART data.
// A push into a full FIFO is dropped unless a pop frees a slot that cycle.
module j1_uart_rx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       resetq,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] head,
    output logic       full,
    output logic       empty,
    output logic       drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/j1_uart_io.sv
// j1_uart_io: J1 IO-bus UART responder (DATA/STATUS/CTRL, RX FIFO, IRQ).
// Define UART_LOOPBACK_EN to enable the CTRL loopback bit.
module j1_uart_io
    import j1_io_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR    = 16'h1000,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          RX_DEPTH     = 8
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_dout,
    output logic [15:0] io_din,
    output logic        interrupt_request,
    input  logic        uart_rxd,
    output logic        uart_txd
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [15:0] ADDR_DATA   = BASE_ADDR + DATA_OFS;
    localparam logic [15:0] ADDR_STATUS = BASE_ADDR + STATUS_OFS;
    localparam logic [15:0] ADDR_CTRL   = BASE_ADDR + CTRL_OFS;

    logic        sel_data;
    logic        sel_stat;
    logic        sel_ctrl;
    logic        rd_data;
    logic        rd_stat;
    logic        wr_data;
    logic        wr_ctrl;

    logic        irq_en;
    logic        overrun;
    logic [15:0] status_val;
    logic [15:0] ctrl_val;

    logic [1:0]  rx_sync;
    logic        rx_in;

    logic [7:0]  fifo_head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_drop;

    uart_state_t tx_state;
    uart_state_t tx_state_n;
    logic [CW-1:0] tx_cnt;
    logic [CW-1:0] tx_cnt_n;
    logic [2:0]  tx_bit;
    logic [2:0]  tx_bit_n;
    logic [7:0]  tx_shift;
    logic [7:0]  tx_shift_n;
    logic        tx_line;
    logic        tx_line_n;
    logic        tx_busy;

    uart_state_t rx_state;
    uart_state_t rx_state_n;
    logic [CW-1:0] rx_cnt;
    logic [CW-1:0] rx_cnt_n;
    logic [2:0]  rx_bit;
    logic [2:0]  rx_bit_n;
    logic [7:0]  rx_shift;
    logic [7:0]  rx_shift_n;
    logic        rx_push;

    logic        unused_bits;
    assign unused_bits = ^io_dout[15:8];

    assign sel_data = (io_addr == ADDR_DATA);
    assign sel_stat = (io_addr == ADDR_STATUS);
    assign sel_ctrl = (io_addr == ADDR_CTRL);
    assign rd_data  = io_rd & sel_data;
    assign rd_stat  = io_rd & sel_stat;
    assign wr_data  = io_wr & sel_data;
    assign wr_ctrl  = io_wr & sel_ctrl;
    assign tx_busy  = (tx_state != UART_IDLE);

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            irq_en <= 1'b0;
        end else if (wr_ctrl) begin
            irq_en <= io_dout[CTRL_IRQ_EN];
        end
    end

`ifdef UART_LOOPBACK_EN
    logic loopback;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            loopback <= 1'b0;
        end else if (wr_ctrl) begin
            loopback <= io_dout[CTRL_LOOPBACK];
        end
    end

    // Loopback feeds the TX line straight in, skipping the synchronizer.
    assign rx_in    = loopback ? tx_line : rx_sync[1];
    assign uart_txd = loopback | tx_line;
`else
    assign rx_in    = rx_sync[1];
    assign uart_txd = tx_line;
`endif

    always_comb begin
        status_val = '0;
        status_val[ST_RX_AVAIL]   = ~fifo_empty;
        status_val[ST_TX_BUSY]    = tx_busy;
        status_val[ST_RX_OVERRUN] = overrun;
        status_val[ST_RX_FULL]    = fifo_full;
        ctrl_val = '0;
        ctrl_val[CTRL_IRQ_EN] = irq_en;
`ifdef UART_LOOPBACK_EN
        ctrl_val[CTRL_LOOPBACK] = loopback;
`endif
    end

    always_comb begin
        io_din = '0;
        if (io_rd) begin
            unique case (1'b1)
                sel_data: io_din = fifo_empty ? 16'h0000 : {8'h00, fifo_head};
                sel_stat: io_din = status_val;
                sel_ctrl: io_din = ctrl_val;
                default:  io_din = '0;
            endcase
        end
    end

    // A drop in the same cycle as a STATUS read keeps the flag set.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            overrun           <= 1'b0;
            interrupt_request <= 1'b0;
        end else begin
            if (fifo_drop) begin
                overrun <= 1'b1;
            end else if (rd_stat) begin
                overrun <= 1'b0;
            end
            interrupt_request <= irq_en & ~fifo_empty;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], uart_rxd};
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_state <= UART_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx_line  <= tx_line_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = (tx_cnt == BIT_LAST) ? '0 : tx_cnt + CW'(1);
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_line_n  = tx_line;
        unique case (tx_state)
            UART_IDLE: begin
                tx_cnt_n = '0;
                if (wr_data) begin
                    tx_state_n = UART_START;
                    tx_shift_n = io_dout[7:0];
                    tx_line_n  = 1'b0;
                end
            end
            UART_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_state_n = UART_DATA;
                    tx_bit_n   = '0;
                    tx_line_n  = tx_shift[0];
                end
            end
            UART_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    if (tx_bit == 3'd7) begin
                        tx_state_n = UART_STOP;
                        tx_line_n  = 1'b1;
                    end else begin
                        tx_bit_n   = tx_bit + 3'd1;
                        tx_shift_n = {1'b0, tx_shift[7:1]};
                        tx_line_n  = tx_shift[1];
                    end
                end
            end
            UART_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_state_n = UART_IDLE;
                end
            end
            default: tx_state_n = UART_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_state <= UART_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    // START waits half a bit, then every later sample lands mid-bit.
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + CW'(1);
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_push    = 1'b0;
        unique case (rx_state)
            UART_IDLE: begin
                rx_cnt_n = '0;
                if (!rx_in) begin
                    rx_state_n = UART_START;
                end
            end
            UART_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rx_in ? UART_IDLE : UART_DATA;
                end
            end
            UART_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_in, rx_shift[7:1]};
                    rx_bit_n   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) begin
                        rx_state_n = UART_STOP;
                    end
                end
            end
            UART_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_push    = rx_in;
                    rx_state_n = UART_IDLE;
                end
            end
            default: rx_state_n = UART_IDLE;
        endcase
    end

    j1_uart_rx_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk    (clk),
        .resetq (resetq),
        .push   (rx_push),
        .pop    (rd_data),
        .din    (rx_shift),
        .head   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .drop   (fifo_drop)
    );

endmodule

// File: tb/tb_j1_uart_io.sv
// tb_j1_uart_io: directed bench for j1_uart_io (CLKS_PER_BIT=4, RX_DEPTH=4).
// Loopback scenario is selected by UART_LOOPBACK_EN.
module tb_j1_uart_io;

    logic        clk;
    logic        resetq;
    logic        io_rd;
    logic        io_wr;
    logic [15:0] io_addr;
    logic [15:0] io_dout;
    logic [15:0] io_din;
    logic        interrupt_request;
    logic        uart_rxd;
    logic        uart_txd;

    int nchecks = 0;
    int nerrors = 0;

    j1_uart_io #(
        .BASE_ADDR    (16'h1000),
        .CLKS_PER_BIT (4),
        .RX_DEPTH     (4)
    ) dut (
        .clk               (clk),
        .resetq            (resetq),
        .io_rd             (io_rd),
        .io_wr             (io_wr),
        .io_addr           (io_addr),
        .io_dout           (io_dout),
        .io_din            (io_din),
        .interrupt_request (interrupt_request),
        .uart_rxd          (uart_rxd),
        .uart_txd          (uart_txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        @(negedge clk);
        io_addr = a;
        io_rd   = 1'b1;
        #1 d = io_din;
        @(posedge clk);
        #1 io_rd = 1'b0;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] v);
        @(negedge clk);
        io_addr = a;
        io_dout = v;
        io_wr   = 1'b1;
        @(posedge clk);
        #1 io_wr = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            uart_rxd = f[i];
            repeat (3) @(negedge clk);
        end
        @(negedge clk);
        uart_rxd = 1'b1;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        resetq   = 1'b0;
        io_rd    = 1'b0;
        io_wr    = 1'b0;
        io_addr  = 16'h0000;
        io_dout  = 16'h0000;
        uart_rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nchecks++;
        if (uart_txd !== 1'b1) begin
            nerrors++;
            $display("FAIL reset_txd: got %b want 1", uart_txd);
        end
        nchecks++;
        if (interrupt_request !== 1'b0) begin
            nerrors++;
            $display("FAIL reset_irq: got %b want 0", interrupt_request);
        end
        nchecks++;
        if (io_din !== 16'h0000) begin
            nerrors++;
            $display("FAIL reset_din: got %h want 0000", io_din);
        end
        @(negedge clk);
        resetq = 1'b1;
        bus_read(16'h1002, d);
        nchecks++;
        if (d !== 16'h0000) begin
            nerrors++;
            $display("FAIL reset_status: got %h want 0000", d);
        end
        bus_read(16'h1004, d);
        nchecks++;
        if (d !== 16'h0000) begin
            nerrors++;
            $display("FAIL reset_ctrl: got %h want 0000", d);
        end
    endtask

    task automatic test_tx();
        logic [9:0]  fr;
        logic [15:0] d;
        fr = {1'b1, 8'hA5, 1'b0};
        bus_write(16'h1000, 16'h00A5);
        for (int k = 0; k < 40; k++) begin
            nchecks++;
            if (uart_txd !== fr[k / 4]) begin
                nerrors++;
                $display("FAIL tx_frame[%0d]: got %b want %b", k, uart_txd, fr[k / 4]);
            end
            if (k == 12) begin
                io_addr = 16'h1000;
                io_dout = 16'h00FF;
                io_wr   = 1'b1;
            end
            if (k == 13) io_wr = 1'b0;
            if (k == 24) begin
                io_addr = 16'h1002;
                io_rd   = 1'b1;
                #1;
                nchecks++;
                if (io_din !== 16'h0002) begin
                    nerrors++;
                    $display("FAIL tx_busy_mid: got %h want 0002", io_din);
                end
            end
            if (k == 25) io_rd = 1'b0;
            @(posedge clk);
            #1;
        end
        bus_read(16'h1002, d);
        nchecks++;
        if (d !== 16'h0000) begin
            nerrors++;
            $display("FAIL tx_idle_status: got %h want 0000", d);
        end
        nchecks++;
        if (uart_txd !== 1'b1) begin
            nerrors++;
            $display("FAIL tx_idle_line: got %b want 1", uart_txd);
        end
    endtask

    task automatic test_rx_irq();
        logic [15:0] d;
        bus_write(16'h1004, 16'h0001);
        send_byte(8'h3C, 1'b1);
        for (int i = 0; i < 16; i++) begin
            if (interrupt_request) break;
            @(posedge clk);
            #1;
        end
        nchecks++;
        if (interrupt_request !== 1'b1) begin
            nerrors++;
            $display("FAIL rx_irq_rise: got %b want 1", interrupt_request);
        end
        bus_read(16'h1000, d);
        nchecks++;
        if (d !== 16'h003C) begin
            nerrors++;
            $display("FAIL rx_data: got %h want 003c", d);
        end
        nchecks++;
        if (interrupt_request !== 1'b1) begin
            nerrors++;
            $display("FAIL rx_irq_hold: got %b want 1", interrupt_request);
        end
        @(posedge clk);
        #1;
        nchecks++;
        if (interrupt_request !== 1'b0) begin
            nerrors++;
            $display("FAIL rx_irq_fall: got %b want 0", interrupt_request);
        end
    endtask

    task automatic test_overrun();
        logic [15:0] d;
        logic [15:0] want;
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i), 1'b1);
        end
        repeat (8) @(posedge clk);
        #1;
        nchecks++;
        if (interrupt_request !== 1'b1) begin
            nerrors++;
            $display("FAIL ovr_irq: got %b want 1", interrupt_request);
        end
        bus_read(16'h1002, d);
        nchecks++;
        if (d !== 16'h000D) begin
            nerrors++;
            $display("FAIL ovr_status: got %h want 000d", d);
        end
        for (int i = 1; i <= 5; i++) begin
            want = (i == 5) ? 16'h0000 : 16'(i);
            bus_read(16'h1000, d);
            nchecks++;
            if (d !== want) begin
                nerrors++;
                $display("FAIL ovr_data[%0d]: got %h want %h", i, d, want);
            end
        end
        bus_read(16'h1002, d);
        nchecks++;
        if (d !== 16'h0000) begin
            nerrors++;
            $display("FAIL ovr_cleared: got %h want 0000", d);
        end
    endtask

    task automatic test_framing();
        logic [15:0] d;
        @(negedge clk);
        uart_rxd = 1'b0;
        @(negedge clk);
        uart_rxd = 1'b1;
        repeat (10) @(posedge clk);
        bus_read(16'h1002, d);
        nchecks++;
        if (d !== 16'h0000) begin
            nerrors++;
            $display("FAIL glitch_status: got %h want 0000", d);
        end
        send_byte(8'h77, 1'b0);
        repeat (12) @(posedge clk);
        bus_read(16'h1002, d);
        nchecks++;
        if (d !== 16'h0000) begin
            nerrors++;
            $display("FAIL frame_err_status: got %h want 0000", d);
        end
        send_byte(8'h5A, 1'b1);
        repeat (8) @(posedge clk);
        bus_read(16'h1000, d);
        nchecks++;
        if (d !== 16'h005A) begin
            nerrors++;
            $display("FAIL rx_recover: got %h want 005a", d);
        end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] d;
        bus_write(16'h1000, 16'h0000);
        repeat (5) @(posedge clk);
        #1;
        nchecks++;
        if (uart_txd !== 1'b0) begin
            nerrors++;
            $display("FAIL mid_line_low: got %b want 0", uart_txd);
        end
        @(negedge clk);
        resetq = 1'b0;
        #1;
        nchecks++;
        if (uart_txd !== 1'b1) begin
            nerrors++;
            $display("FAIL mid_reset_txd: got %b want 1", uart_txd);
        end
        @(negedge clk);
        resetq = 1'b1;
        bus_read(16'h1002, d);
        nchecks++;
        if (d !== 16'h0000) begin
            nerrors++;
            $display("FAIL mid_reset_status: got %h want 0000", d);
        end
        bus_read(16'h1004, d);
        nchecks++;
        if (d !== 16'h0000) begin
            nerrors++;
            $display("FAIL mid_reset_ctrl: got %h want 0000", d);
        end
    endtask

    task automatic test_loopback();
        logic [15:0] d;
        bus_write(16'h1004, 16'h0003);
        bus_read(16'h1004, d);
`ifdef UART_LOOPBACK_EN
        nchecks++;
        if (d !== 16'h0003) begin
            nerrors++;
            $display("FAIL lb_ctrl: got %h want 0003", d);
        end
        bus_write(16'h1000, 16'h005A);
        for (int k = 0; k < 50; k++) begin
            nchecks++;
            if (uart_txd !== 1'b1) begin
                nerrors++;
                $display("FAIL lb_txd_held[%0d]: got %b want 1", k, uart_txd);
            end
            @(posedge clk);
            #1;
        end
        bus_read(16'h1000, d);
        nchecks++;
        if (d !== 16'h005A) begin
            nerrors++;
            $display("FAIL lb_data: got %h want 005a", d);
        end
`else
        nchecks++;
        if (d !== 16'h0001) begin
            nerrors++;
            $display("FAIL ctrl_no_lb: got %h want 0001", d);
        end
`endif
        bus_write(16'h1004, 16'h0000);
    endtask

    initial begin
        test_reset();
        test_tx();
        test_rx_irq();
        test_overrun();
        test_framing();
        test_reset_midframe();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
